// File: rtl/axi4_rd_arbiter_pkg.sv
// Shared types and constants for the AXI4 read-port arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package axi4_arb_pkg;

  // Arbiter FSM: wait for a request, present AR to the slave, stream R beats.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } state_t;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

endpackage

// File: rtl/axi4_rd_arbiter_if.sv
// AR/R signal bundle between the requesting masters, the arbiter and the memory slave.
// Latency: n/a (wires only).
// Backpressure: plain AXI valid/ready on every channel.
interface axi4_rd_arbiter_if #(
  parameter int NUM_MASTERS = 2,
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int ID_WIDTH    = 4,
  parameter int LEN_WIDTH   = 8
);
  // Requester side: per-master vectors, master i at [i*W +: W].
  logic [NUM_MASTERS-1:0]            S_ARVALID;
  logic [NUM_MASTERS-1:0]            S_ARREADY;
  logic [NUM_MASTERS*ID_WIDTH-1:0]   S_ARID;
  logic [NUM_MASTERS*ADDR_WIDTH-1:0] S_ARADDR;
  logic [NUM_MASTERS*LEN_WIDTH-1:0]  S_ARLEN;
  logic [NUM_MASTERS*3-1:0]          S_ARSIZE;
  logic [NUM_MASTERS*2-1:0]          S_ARBURST;
  logic [NUM_MASTERS-1:0]            S_RVALID;
  logic [NUM_MASTERS-1:0]            S_RREADY;
  logic [ID_WIDTH-1:0]               S_RID;
  logic [DATA_WIDTH-1:0]             S_RDATA;
  logic [1:0]                        S_RRESP;
  logic                              S_RLAST;

  // Memory-slave side: single AXI4 read port.
  logic                              M_ARVALID;
  logic                              M_ARREADY;
  logic [ID_WIDTH-1:0]               M_ARID;
  logic [ADDR_WIDTH-1:0]             M_ARADDR;
  logic [LEN_WIDTH-1:0]              M_ARLEN;
  logic [2:0]                        M_ARSIZE;
  logic [1:0]                        M_ARBURST;
  logic                              M_RVALID;
  logic                              M_RREADY;
  logic [ID_WIDTH-1:0]               M_RID;
  logic [DATA_WIDTH-1:0]             M_RDATA;
  logic [1:0]                        M_RRESP;
  logic                              M_RLAST;

  // Arbiter's view: slave to the requesters, master to the memory.
  modport slave (
    input  S_ARVALID, S_ARID, S_ARADDR, S_ARLEN, S_ARSIZE, S_ARBURST, S_RREADY,
    output S_ARREADY, S_RVALID, S_RID, S_RDATA, S_RRESP, S_RLAST,
    output M_ARVALID, M_ARID, M_ARADDR, M_ARLEN, M_ARSIZE, M_ARBURST, M_RREADY,
    input  M_ARREADY, M_RVALID, M_RID, M_RDATA, M_RRESP, M_RLAST
  );

  // Surrounding system's view: the requesters plus the memory slave.
  modport master (
    output S_ARVALID, S_ARID, S_ARADDR, S_ARLEN, S_ARSIZE, S_ARBURST, S_RREADY,
    input  S_ARREADY, S_RVALID, S_RID, S_RDATA, S_RRESP, S_RLAST,
    input  M_ARVALID, M_ARID, M_ARADDR, M_ARLEN, M_ARSIZE, M_ARBURST, M_RREADY,
    output M_ARREADY, M_RVALID, M_RID, M_RDATA, M_RRESP, M_RLAST
  );
endinterface

// File: rtl/axi4_rd_arbiter_rr_arbiter.sv
// Round-robin pick: first asserted request at or above ptr, wrapping modulo N.
// Latency: purely combinational.
// Backpressure: none; the caller owns the pointer register.
module rr_arbiter #(
  parameter  int N  = 2,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx,
  output logic          any
);

  // Scan N positions starting at ptr; the first hit wins.
  always_comb begin
    int j;
    j         = 0;
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    for (int k = 0; k < N; k++) begin
      j = int'(ptr) + k;
      if (j >= N) j = j - N;
      if (!any && req[j]) begin
        any       = 1'b1;
        grant[j]  = 1'b1;
        grant_idx = IW'(j);
      end
    end
  end

endmodule

// File: rtl/axi4_rd_arbiter.sv
// Shares one AXI4 read port between NUM_MASTERS requesters, round-robin, one burst in flight.
// Latency: AR accepted in IDLE, presented to the slave next cycle; one IDLE cycle after RLAST.
// Backpressure: S_ARREADY only in IDLE; M_ARVALID held until M_ARREADY; M_RREADY mirrors owner's S_RREADY.
module axi4_rd_arbiter
  import axi4_arb_pkg::*;
#(
  parameter  int NUM_MASTERS = 2,
  parameter  int ADDR_WIDTH  = 32,
  parameter  int DATA_WIDTH  = 32,
  parameter  int ID_WIDTH    = 4,
  parameter  int LEN_WIDTH   = 8,
  localparam int GW          = $clog2(NUM_MASTERS)
) (
  input  logic            ACLK,
  input  logic            ARESET,
  axi4_rd_arbiter_if.slave bus,
  output logic [GW-1:0]   GRANT,
  output logic            BUSY,
  output logic            LEN_ERR
);

  state_t                 state_q, state_d;
  logic [GW-1:0]          rr_ptr_q;
  logic [GW-1:0]          grant_q;
  logic [LEN_WIDTH:0]     beat_cnt_q;
  logic [LEN_WIDTH:0]     beat_inc;
  logic                   len_err_q;

  logic [ID_WIDTH-1:0]    ar_id_q;
  logic [ADDR_WIDTH-1:0]  ar_addr_q;
  logic [LEN_WIDTH-1:0]   ar_len_q;
  logic [2:0]             ar_size_q;
  logic [1:0]             ar_burst_q;

  logic [ID_WIDTH-1:0]    nxt_id;
  logic [ADDR_WIDTH-1:0]  nxt_addr;
  logic [LEN_WIDTH-1:0]   nxt_len;
  logic [2:0]             nxt_size;
  logic [1:0]             nxt_burst;

  logic [NUM_MASTERS-1:0] win_oh;
  logic [GW-1:0]          win_idx;
  logic                   win_any;
  logic                   ar_take;
  logic                   rready_c;
  logic                   r_beat;
  logic [DATA_WIDTH-1:0]  r_data;

  rr_arbiter #(.N(NUM_MASTERS)) u_rr (
    .req       (bus.S_ARVALID),
    .ptr       (rr_ptr_q),
    .grant     (win_oh),
    .grant_idx (win_idx),
    .any       (win_any)
  );

  assign ar_take  = (state_q == IDLE) && win_any;
  assign rready_c = bus.S_RREADY[grant_q];
  assign r_beat   = (state_q == DATA) && bus.M_RVALID && rready_c;
  // Counter saturates rather than wrapping, so a runaway burst still reads as a mismatch.
  assign beat_inc = (beat_cnt_q == '1) ? beat_cnt_q : beat_cnt_q + 1'b1;

  // Select the winning master's AR payload from the packed request vectors.
  always_comb begin
    nxt_id    = '0;
    nxt_addr  = '0;
    nxt_len   = '0;
    nxt_size  = '0;
    nxt_burst = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (win_oh[i]) begin
        nxt_id    = bus.S_ARID[i*ID_WIDTH +: ID_WIDTH];
        nxt_addr  = bus.S_ARADDR[i*ADDR_WIDTH +: ADDR_WIDTH];
        nxt_len   = bus.S_ARLEN[i*LEN_WIDTH +: LEN_WIDTH];
        nxt_size  = bus.S_ARSIZE[i*3 +: 3];
        nxt_burst = bus.S_ARBURST[i*2 +: 2];
      end
    end
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_d       = state_q;
    bus.S_ARREADY = '0;
    bus.S_RVALID  = '0;
    bus.M_ARVALID = 1'b0;
    bus.M_RREADY  = 1'b0;
    case (state_q)
      IDLE: begin
        if (win_any) begin
          bus.S_ARREADY = win_oh;
          state_d       = ADDR;
        end
      end
      ADDR: begin
        bus.M_ARVALID = 1'b1;
        if (bus.M_ARREADY) state_d = DATA;
      end
      DATA: begin
        bus.M_RREADY          = rready_c;
        bus.S_RVALID[grant_q] = bus.M_RVALID;
        if (r_beat && bus.M_RLAST) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, owner, beat count and sticky length-error bookkeeping.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      grant_q    <= '0;
      beat_cnt_q <= '0;
      len_err_q  <= 1'b0;
      ar_id_q    <= '0;
      ar_addr_q  <= '0;
      ar_len_q   <= '0;
      ar_size_q  <= '0;
      ar_burst_q <= '0;
    end else begin
      state_q <= state_d;
      if (ar_take) begin
        ar_id_q    <= nxt_id;
        ar_addr_q  <= nxt_addr;
        ar_len_q   <= nxt_len;
        ar_size_q  <= nxt_size;
        ar_burst_q <= nxt_burst;
        grant_q    <= win_idx;
        beat_cnt_q <= '0;
      end
      if (r_beat) begin
        beat_cnt_q <= beat_inc;
        if (bus.M_RLAST) begin
          if (beat_inc != ({1'b0, ar_len_q} + 1'b1)) len_err_q <= 1'b1;
          rr_ptr_q <= (grant_q == GW'(NUM_MASTERS - 1)) ? '0 : grant_q + 1'b1;
        end
      end
    end
  end

  assign bus.M_ARID    = ar_id_q;
  assign bus.M_ARADDR  = ar_addr_q;
  assign bus.M_ARLEN   = ar_len_q;
  assign bus.M_ARSIZE  = ar_size_q;
  assign bus.M_ARBURST = ar_burst_q;

  assign r_data        = bus.M_RDATA;
  assign bus.S_RDATA   = r_data;
  assign bus.S_RID     = bus.M_RID;
  assign bus.S_RRESP   = bus.M_RRESP;
  assign bus.S_RLAST   = bus.M_RLAST;

  assign GRANT   = grant_q;
  assign BUSY    = (state_q != IDLE);
  assign LEN_ERR = len_err_q;

endmodule

// File: tb/tb_axi4_rd_arbiter.sv
// Directed bench for axi4_rd_arbiter: cycle table for arbitration, hand sequences for bursts.
// Latency: n/a.
// Backpressure: bench plays both the masters and a cooperative memory slave.
module tb_axi4_rd_arbiter;
  import axi4_arb_pkg::*;

  logic       ACLK;
  logic       ARESET;
  logic [0:0] GRANT;
  logic       BUSY;
  logic       LEN_ERR;

  int n_cmp = 0;
  int n_err = 0;

  axi4_rd_arbiter_if #(.NUM_MASTERS(2), .ADDR_WIDTH(32), .DATA_WIDTH(32),
                       .ID_WIDTH(4), .LEN_WIDTH(8)) bus ();

  axi4_rd_arbiter #(.NUM_MASTERS(2), .ADDR_WIDTH(32), .DATA_WIDTH(32),
                    .ID_WIDTH(4), .LEN_WIDTH(8)) dut (
    .ACLK    (ACLK),
    .ARESET  (ARESET),
    .bus     (bus),
    .GRANT   (GRANT),
    .BUSY    (BUSY),
    .LEN_ERR (LEN_ERR)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  // One row = one clock cycle: inputs driven, outputs expected within that cycle.
  typedef struct {
    logic        rst;
    logic [1:0]  arv;
    logic        arrdy;
    logic        rvld;
    logic        rlast;
    logic [1:0]  rrdy;
    logic [1:0]  e_arrdy;
    logic        e_marv;
    logic        e_mrrdy;
    logic [1:0]  e_rvld;
    logic        e_busy;
    logic        e_grant;
    logic [31:0] e_addr;
  } vec_t;

  function automatic vec_t mk(logic rst, logic [1:0] arv, logic arrdy, logic rvld,
                              logic rlast, logic [1:0] rrdy, logic [1:0] e_arrdy,
                              logic e_marv, logic e_mrrdy, logic [1:0] e_rvld,
                              logic e_busy, logic e_grant, logic [31:0] e_addr);
    vec_t v;
    v.rst = rst;  v.arv = arv;  v.arrdy = arrdy;  v.rvld = rvld;  v.rlast = rlast;
    v.rrdy = rrdy;  v.e_arrdy = e_arrdy;  v.e_marv = e_marv;  v.e_mrrdy = e_mrrdy;
    v.e_rvld = e_rvld;  v.e_busy = e_busy;  v.e_grant = e_grant;  v.e_addr = e_addr;
    return v;
  endfunction

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic set_ar(input int m, input logic [31:0] addr, input logic [7:0] len,
                        input logic [3:0] id);
    bus.S_ARADDR[m*32 +: 32] = addr;
    bus.S_ARLEN[m*8 +: 8]    = len;
    bus.S_ARID[m*4 +: 4]     = id;
    bus.S_ARSIZE[m*3 +: 3]   = 3'd2;
    bus.S_ARBURST[m*2 +: 2]  = BURST_INCR;
  endtask

  // Request from master m, wait (bounded) for its grant, then complete the AR handshake.
  task automatic do_ar(input int m, input logic [31:0] addr);
    int t;
    bus.S_ARVALID[m] = 1'b1;
    #1;
    t = 0;
    while (!bus.S_ARREADY[m] && t < 10) begin
      tick();
      t++;
    end
    chk($sformatf("ar_grant_m%0d", m), {63'd0, bus.S_ARREADY[m]}, 64'd1);
    tick();
    bus.S_ARVALID[m] = 1'b0;
    bus.M_ARREADY    = 1'b1;
    #1;
    chk($sformatf("ar_addr_m%0d", m), {31'd0, bus.M_ARVALID, bus.M_ARADDR}, {31'd1, addr});
    tick();
    bus.M_ARREADY = 1'b0;
  endtask

  vec_t tbl[19];
  logic [31:0] got_q[$];
  logic [15:0] pat;

  initial begin
    ARESET        = 1'b1;
    bus.S_ARVALID = '0;
    bus.S_RREADY  = '0;
    bus.S_ARID    = '0;
    bus.S_ARADDR  = '0;
    bus.S_ARLEN   = '0;
    bus.S_ARSIZE  = '0;
    bus.S_ARBURST = '0;
    bus.M_ARREADY = 1'b0;
    bus.M_RVALID  = 1'b0;
    bus.M_RID     = '0;
    bus.M_RDATA   = '0;
    bus.M_RRESP   = RESP_OKAY;
    bus.M_RLAST   = 1'b0;
    set_ar(0, 32'h04, 8'd0, 4'd1);
    set_ar(1, 32'h10, 8'd0, 4'd2);

    //           rst arv   ard rv rl rrdy  | e_ard e_mav e_mrr e_rv  busy gnt addr
    tbl[0]  = mk(0, 2'b01, 0, 0, 0, 2'b00, 2'b01, 0, 0, 2'b00, 0, 0, 32'h00);
    tbl[1]  = mk(0, 2'b00, 1, 0, 0, 2'b00, 2'b00, 1, 0, 2'b00, 1, 0, 32'h04);
    tbl[2]  = mk(0, 2'b00, 0, 1, 1, 2'b00, 2'b00, 0, 0, 2'b01, 1, 0, 32'h00);
    tbl[3]  = mk(0, 2'b00, 0, 1, 1, 2'b01, 2'b00, 0, 1, 2'b01, 1, 0, 32'h00);
    tbl[4]  = mk(0, 2'b00, 0, 0, 0, 2'b00, 2'b00, 0, 0, 2'b00, 0, 0, 32'h00);
    tbl[5]  = mk(1, 2'b00, 0, 0, 0, 2'b00, 2'b00, 0, 0, 2'b00, 0, 0, 32'h00);
    tbl[6]  = mk(0, 2'b11, 0, 0, 0, 2'b00, 2'b01, 0, 0, 2'b00, 0, 0, 32'h00);
    tbl[7]  = mk(0, 2'b10, 1, 0, 0, 2'b00, 2'b00, 1, 0, 2'b00, 1, 0, 32'h04);
    tbl[8]  = mk(0, 2'b10, 0, 1, 1, 2'b11, 2'b00, 0, 1, 2'b01, 1, 0, 32'h00);
    tbl[9]  = mk(0, 2'b10, 0, 0, 0, 2'b00, 2'b10, 0, 0, 2'b00, 0, 0, 32'h00);
    tbl[10] = mk(0, 2'b00, 1, 0, 0, 2'b00, 2'b00, 1, 0, 2'b00, 1, 1, 32'h10);
    tbl[11] = mk(0, 2'b00, 0, 1, 1, 2'b10, 2'b00, 0, 1, 2'b10, 1, 1, 32'h00);
    tbl[12] = mk(0, 2'b11, 0, 0, 0, 2'b00, 2'b01, 0, 0, 2'b00, 0, 0, 32'h00);
    tbl[13] = mk(0, 2'b10, 1, 0, 0, 2'b00, 2'b00, 1, 0, 2'b00, 1, 0, 32'h04);
    tbl[14] = mk(0, 2'b10, 0, 1, 1, 2'b11, 2'b00, 0, 1, 2'b01, 1, 0, 32'h00);
    tbl[15] = mk(0, 2'b10, 0, 0, 0, 2'b00, 2'b10, 0, 0, 2'b00, 0, 0, 32'h00);
    tbl[16] = mk(0, 2'b00, 1, 0, 0, 2'b00, 2'b00, 1, 0, 2'b00, 1, 1, 32'h10);
    tbl[17] = mk(0, 2'b00, 0, 1, 1, 2'b10, 2'b00, 0, 1, 2'b10, 1, 1, 32'h00);
    tbl[18] = mk(0, 2'b00, 0, 0, 0, 2'b00, 2'b00, 0, 0, 2'b00, 0, 0, 32'h00);

    // Reset state
    repeat (3) @(posedge ACLK);
    #1;
    ARESET = 1'b0;
    #1;
    chk("rst_busy",    {63'd0, BUSY}, 64'd0);
    chk("rst_grant",   {63'd0, GRANT}, 64'd0);
    chk("rst_lenerr",  {63'd0, LEN_ERR}, 64'd0);
    chk("rst_hs", {59'd0, bus.S_ARREADY, bus.M_ARVALID, bus.M_RREADY, bus.S_RVALID}, 64'd0);
    chk("rst_ar", {bus.M_ARID, bus.M_ARADDR, bus.M_ARLEN, bus.M_ARSIZE, bus.M_ARBURST}, 64'd0);

    // Single request, contention and round-robin order, cycle by cycle.
    for (int i = 0; i < 19; i++) begin
      ARESET        = tbl[i].rst;
      bus.S_ARVALID = tbl[i].arv;
      bus.M_ARREADY = tbl[i].arrdy;
      bus.M_RVALID  = tbl[i].rvld;
      bus.M_RLAST   = tbl[i].rlast;
      bus.S_RREADY  = tbl[i].rrdy;
      #1;
      chk($sformatf("tbl[%0d]", i),
          {55'd0, bus.S_ARREADY, bus.M_ARVALID, bus.M_RREADY, bus.S_RVALID, BUSY,
           (tbl[i].e_busy ? GRANT[0] : 1'b0), LEN_ERR},
          {55'd0, tbl[i].e_arrdy, tbl[i].e_marv, tbl[i].e_mrrdy, tbl[i].e_rvld,
           tbl[i].e_busy, (tbl[i].e_busy ? tbl[i].e_grant : 1'b0), 1'b0});
      if (tbl[i].e_marv)
        chk($sformatf("tbl[%0d]_addr", i), {32'd0, bus.M_ARADDR}, {32'd0, tbl[i].e_addr});
      tick();
    end
    ARESET        = 1'b0;
    bus.S_ARVALID = '0;
    bus.M_ARREADY = 1'b0;
    bus.M_RVALID  = 1'b0;
    bus.M_RLAST   = 1'b0;
    bus.S_RREADY  = '0;

    // M1 4-beat burst with the slave stalling AR for 5 cycles.
    set_ar(1, 32'h100, 8'd3, 4'd5);
    bus.S_ARVALID = 2'b10;
    #1;
    chk("t3_arready", {62'd0, bus.S_ARREADY}, 64'd2);
    tick();
    bus.S_ARVALID = '0;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk($sformatf("t3_stall%0d", k),
          {14'd0, bus.M_ARVALID, GRANT, bus.M_ARID, bus.M_ARADDR, bus.M_ARLEN,
           bus.M_ARSIZE, bus.M_ARBURST},
          {14'd0, 1'b1, 1'b1, 4'd5, 32'h100, 8'd3, 3'd2, BURST_INCR});
      tick();
    end
    bus.M_ARREADY = 1'b1;
    #1;
    chk("t3_ar_hs", {63'd0, bus.M_ARVALID}, 64'd1);
    tick();
    bus.M_ARREADY = 1'b0;
    bus.S_RREADY  = 2'b11;
    bus.M_RID     = 4'd5;
    for (int k = 0; k < 4; k++) begin
      bus.M_RVALID = 1'b1;
      bus.M_RDATA  = 32'hA0 + k;
      bus.M_RLAST  = (k == 3);
      #1;
      chk($sformatf("t3_beat%0d", k), {26'd0, bus.S_RVALID, bus.S_RID, bus.S_RDATA},
          {26'd0, 2'b10, 4'd5, 32'hA0 + k});
      tick();
    end
    bus.M_RVALID = 1'b0;
    bus.M_RLAST  = 1'b0;
    #1;
    chk("t3_done", {62'd0, BUSY, LEN_ERR}, 64'd0);

    // M0 4-beat burst with the owner's RREADY toggling; the slave holds each beat until taken.
    set_ar(0, 32'h200, 8'd3, 4'd3);
    do_ar(0, 32'h200);
    pat = 16'b1100_1010_0110_1001;
    got_q.delete();
    begin
      int k;
      k = 0;
      for (int c = 0; c < 16 && k < 4; c++) begin
        bus.S_RREADY = {~pat[c], pat[c]};
        bus.M_RVALID = 1'b1;
        bus.M_RDATA  = 32'hB0 + k;
        bus.M_RLAST  = (k == 3);
        #1;
        chk($sformatf("t4_rready%0d", c), {62'd0, bus.M_RREADY, bus.S_RVALID[1]},
            {62'd0, pat[c], 1'b0});
        if (pat[c]) begin
          got_q.push_back(bus.S_RDATA);
          k++;
        end
        tick();
      end
    end
    bus.M_RVALID = 1'b0;
    bus.M_RLAST  = 1'b0;
    chk("t4_count", 64'(got_q.size()), 64'd4);
    for (int i = 0; i < got_q.size(); i++)
      chk($sformatf("t4_order%0d", i), {32'd0, got_q[i]}, {32'd0, 32'hB0 + i});
    #1;
    chk("t4_idle", {63'd0, BUSY}, 64'd0);

    // M1 ARLEN=3 but the slave ends after three beats.
    set_ar(1, 32'h300, 8'd3, 4'd6);
    do_ar(1, 32'h300);
    bus.S_RREADY = 2'b11;
    for (int k = 0; k < 3; k++) begin
      bus.M_RVALID = 1'b1;
      bus.M_RDATA  = 32'hC0 + k;
      bus.M_RLAST  = (k == 2);
      #1;
      if (k == 2) chk("t5_pre_err", {63'd0, LEN_ERR}, 64'd0);
      tick();
    end
    bus.M_RVALID = 1'b0;
    bus.M_RLAST  = 1'b0;
    #1;
    chk("t5_err_set", {62'd0, LEN_ERR, BUSY}, 64'd2);
    set_ar(0, 32'h04, 8'd0, 4'd1);
    do_ar(0, 32'h04);
    bus.M_RVALID = 1'b1;
    bus.M_RLAST  = 1'b1;
    tick();
    bus.M_RVALID = 1'b0;
    bus.M_RLAST  = 1'b0;
    #1;
    chk("t5_err_sticky", {62'd0, LEN_ERR, BUSY}, 64'd2);

    // Reset in the middle of an M0 burst, then a lone M1 request.
    set_ar(0, 32'h400, 8'd1, 4'd7);
    do_ar(0, 32'h400);
    bus.S_RREADY = 2'b01;
    bus.M_RVALID = 1'b1;
    bus.M_RLAST  = 1'b0;
    tick();
    bus.M_RVALID = 1'b0;
    bus.S_RREADY = 2'b00;
    ARESET       = 1'b1;
    #1;
    chk("t6_busy_pre", {63'd0, BUSY}, 64'd1);
    tick();
    ARESET = 1'b0;
    #1;
    chk("t6_rst_state", {60'd0, BUSY, GRANT, LEN_ERR, bus.M_ARVALID}, 64'd0);
    chk("t6_rst_hs", {60'd0, bus.S_ARREADY, bus.M_RREADY, bus.S_RVALID[0]}, 64'd0);
    chk("t6_rst_ar", {bus.M_ARID, bus.M_ARADDR, bus.M_ARLEN, bus.M_ARSIZE, bus.M_ARBURST}, 64'd0);
    set_ar(1, 32'h500, 8'd0, 4'd8);
    bus.S_ARVALID = 2'b10;
    #1;
    chk("t6_m1_arready", {62'd0, bus.S_ARREADY}, 64'd2);
    tick();
    bus.S_ARVALID = '0;
    #1;
    chk("t6_m1_owner", {29'd0, BUSY, GRANT, bus.M_ARVALID, bus.M_ARADDR},
        {29'd0, 1'b1, 1'b1, 1'b1, 32'h500});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

endmodule
